// File: rtl/writeback_stage.sv
// Writeback stage: one-cycle stage register feeding the register-file write port,
// with load extraction, load-fault detection and an optional retire counter (WB_INSTRET_EN).
module writeback_stage #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [4:0]        rd_i,
  input  logic              regwren_i,
  input  logic [1:0]        wbsel_i,
  input  logic [2:0]        funct3_i,
  input  logic [DWIDTH-1:0] alures_i,
  input  logic [DWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] memdata_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [4:0]        rd_o,
  output logic [DWIDTH-1:0] datawb_o,
  output logic              regwren_o,
  output logic              fault_o,
  output logic              retire_o,
  output logic [63:0]       instret_o
);

  logic              r_valid;
  logic [4:0]        r_rd;
  logic              r_regwren;
  logic [1:0]        r_wbsel;
  logic [2:0]        r_funct3;
  logic [DWIDTH-1:0] r_alures;
  logic [DWIDTH-1:0] r_pc;
  logic [DWIDTH-1:0] r_memdata;

  logic              w_capture;
  logic [1:0]        w_off;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DWIDTH-1:0] w_load;
  logic              w_fault;

  assign w_capture = valid_i & ~stall_i & ~flush_i & ~rst;

  always_ff @(posedge clk) begin
    if (rst) r_valid <= 1'b0;
    else     r_valid <= w_capture;
  end

  // Payload fields only matter while r_valid is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_rd      <= rd_i;
      r_regwren <= regwren_i;
      r_wbsel   <= wbsel_i;
      r_funct3  <= funct3_i;
      r_alures  <= alures_i;
      r_pc      <= pc_i;
      r_memdata <= memdata_i;
    end
  end

  assign w_off  = r_alures[1:0];
  assign w_half = w_off[1] ? r_memdata[31:16] : r_memdata[15:0];

  always_comb begin
    w_byte = r_memdata[7:0];
    case (w_off)
      2'd0: w_byte = r_memdata[7:0];
      2'd1: w_byte = r_memdata[15:8];
      2'd2: w_byte = r_memdata[23:16];
      2'd3: w_byte = r_memdata[31:24];
      default: w_byte = r_memdata[7:0];
    endcase
  end

  always_comb begin
    w_load = '0;
    case (r_funct3)
      3'b000: w_load = {{(DWIDTH-8){w_byte[7]}}, w_byte};
      3'b100: w_load = {{(DWIDTH-8){1'b0}}, w_byte};
      3'b001: w_load = {{(DWIDTH-16){w_half[15]}}, w_half};
      3'b101: w_load = {{(DWIDTH-16){1'b0}}, w_half};
      3'b010: w_load = r_memdata;
      default: w_load = '0;
    endcase
  end

  always_comb begin
    w_fault = 1'b0;
    if (r_valid && r_wbsel == 2'b01) begin
      case (r_funct3)
        3'b001, 3'b101:         w_fault = w_off[0];
        3'b010:                 w_fault = (w_off != 2'd0);
        3'b011, 3'b110, 3'b111: w_fault = 1'b1;
        default:                w_fault = 1'b0;
      endcase
    end
  end

  always_comb begin
    datawb_o = '0;
    case (r_wbsel)
      2'b00: datawb_o = r_alures;
      2'b01: datawb_o = w_load;
      2'b10: datawb_o = r_pc + DWIDTH'(4);
      default: datawb_o = '0;
    endcase
  end

  assign rd_o      = r_rd;
  assign fault_o   = w_fault;
  assign retire_o  = r_valid & ~w_fault & ~flush_i;
  assign regwren_o = r_valid & r_regwren & (r_rd != 5'd0) & ~w_fault & ~flush_i;

`ifdef WB_INSTRET_EN
  logic [63:0] r_instret;

  always_ff @(posedge clk) begin
    if (rst)           r_instret <= '0;
    else if (retire_o) r_instret <= r_instret + 64'd1;
  end

  assign instret_o = r_instret;
`else
  assign instret_o = '0;
`endif

endmodule
